// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the data-memory port of dmem_arbiter.
// slave = arbiter side, master = requesters plus memory.
interface dmem_arbiter_if;
    logic        p0_req;
    logic        p0_we;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic [2:0]  p0_op;
    logic        p0_ack;
    logic        p0_err;
    logic [31:0] p0_rdata;

    logic        p1_req;
    logic        p1_we;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic [2:0]  p1_op;
    logic        p1_ack;
    logic        p1_err;
    logic [31:0] p1_rdata;

    logic        mem_wena;
    logic [31:0] mem_raddr;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_choose;
    logic [31:0] mem_rdata;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata, p0_op,
        input  p1_req, p1_we, p1_addr, p1_wdata, p1_op,
        input  mem_rdata,
        output p0_ack, p0_err, p0_rdata,
        output p1_ack, p1_err, p1_rdata,
        output mem_wena, mem_raddr, mem_waddr, mem_wdata, mem_choose
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata, p0_op,
        output p1_req, p1_we, p1_addr, p1_wdata, p1_op,
        output mem_rdata,
        input  p0_ack, p0_err, p0_rdata,
        input  p1_ack, p1_err, p1_rdata,
        input  mem_wena, mem_raddr, mem_waddr, mem_wdata, mem_choose
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the big-endian data memory with range/alignment/opcode checks.
// Latency: req seen in cycle N -> ack in N+2; one transaction per 3 cycles, loser waits holding req.
// DMEM_ARB_STAT_EN adds saturating grant/error counters.
module dmem_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
    parameter int unsigned DEPTH     = 1024
`ifdef DMEM_ARB_STAT_EN
    ,
    parameter int unsigned CNT_W     = 16
`endif
) (
    input  logic                clk,
    input  logic                rst,
    dmem_arbiter_if.slave       bus
`ifdef DMEM_ARB_STAT_EN
    ,
    output logic [CNT_W-1:0]    p0_grant_cnt,
    output logic [CNT_W-1:0]    p1_grant_cnt,
    output logic [CNT_W-1:0]    err_cnt
`endif
);
    localparam logic [32:0] DEPTH_W = 33'(DEPTH);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_nx;
    logic        rr_last, sel_q, we_q, err_q;
    logic        grant_vld, grant_sel;
    logic        sel_we;
    logic [31:0] sel_addr, sel_wdata;
    logic [2:0]  sel_op;
    logic [31:0] offset;
    logic [32:0] last_off;
    logic [2:0]  size;
    logic        sel_err;
    logic        p0_ack_q, p1_ack_q, p0_err_q, p1_err_q;
    logic [31:0] p0_rdata_q, p1_rdata_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [2:0]  mem_choose_q;

    // Winner selection and request validation for the IDLE cycle
    always_comb begin
        grant_vld = bus.p0_req | bus.p1_req;
        grant_sel = (bus.p0_req && bus.p1_req) ? ~rr_last : bus.p1_req;
        sel_we    = grant_sel ? bus.p1_we    : bus.p0_we;
        sel_addr  = grant_sel ? bus.p1_addr  : bus.p0_addr;
        sel_wdata = grant_sel ? bus.p1_wdata : bus.p0_wdata;
        sel_op    = grant_sel ? bus.p1_op    : bus.p0_op;
        case (sel_op)
            3'd0, 3'd1, 3'd5: size = 3'd1;
            3'd2, 3'd3, 3'd7: size = 3'd2;
            default:          size = 3'd4;
        endcase
        offset   = sel_addr - BASE_ADDR;
        last_off = {1'b0, offset} + {30'b0, size} - 33'd1;
        sel_err  = ({1'b0, offset} >= DEPTH_W) || (last_off >= DEPTH_W)
                 || ((size == 3'd2) && sel_addr[0])
                 || ((size == 3'd4) && (sel_addr[1:0] != 2'b00))
                 || (sel_we ? (sel_op < 3'd5) : (sel_op >= 3'd5));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_vld) state_nx = ACCESS;
            ACCESS:  state_nx = RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last      <= 1'b1;
            sel_q        <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_choose_q <= '0;
            p0_ack_q     <= 1'b0;
            p1_ack_q     <= 1'b0;
            p0_err_q     <= 1'b0;
            p1_err_q     <= 1'b0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
        end else begin
            p0_ack_q <= 1'b0;
            p1_ack_q <= 1'b0;
            p0_err_q <= 1'b0;
            p1_err_q <= 1'b0;
            if (state == IDLE && grant_vld) begin
                sel_q        <= grant_sel;
                rr_last      <= grant_sel;
                we_q         <= sel_we;
                err_q        <= sel_err;
                mem_addr_q   <= sel_addr;
                mem_wdata_q  <= sel_wdata;
                mem_choose_q <= sel_op;
            end
            // Response flops load at the end of ACCESS so they are visible throughout RESP
            if (state == ACCESS) begin
                if (sel_q) begin
                    p1_ack_q   <= 1'b1;
                    p1_err_q   <= err_q;
                    p1_rdata_q <= (!we_q && !err_q) ? bus.mem_rdata : 32'h0;
                end else begin
                    p0_ack_q   <= 1'b1;
                    p0_err_q   <= err_q;
                    p0_rdata_q <= (!we_q && !err_q) ? bus.mem_rdata : 32'h0;
                end
            end
        end
    end

    assign bus.mem_wena   = (state == ACCESS) && we_q && !err_q && !rst;
    assign bus.mem_raddr  = mem_addr_q;
    assign bus.mem_waddr  = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_choose = mem_choose_q;
    assign bus.p0_ack     = p0_ack_q;
    assign bus.p1_ack     = p1_ack_q;
    assign bus.p0_err     = p0_err_q;
    assign bus.p1_err     = p1_err_q;
    assign bus.p0_rdata   = p0_rdata_q;
    assign bus.p1_rdata   = p1_rdata_q;

`ifdef DMEM_ARB_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            p0_grant_cnt <= '0;
            p1_grant_cnt <= '0;
            err_cnt      <= '0;
        end else if (state == RESP) begin
            if (!sel_q && p0_grant_cnt != '1) p0_grant_cnt <= p0_grant_cnt + 1'b1;
            if (sel_q && p1_grant_cnt != '1)  p1_grant_cnt <= p1_grant_cnt + 1'b1;
            if (err_q && err_cnt != '1)       err_cnt      <= err_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a big-endian byte memory model.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    localparam logic [31:0] BASE = 32'h1001_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if bus();
`ifdef DMEM_ARB_STAT_EN
    logic [15:0] p0_grant_cnt, p1_grant_cnt, err_cnt;
`endif

    dmem_arbiter #(.BASE_ADDR(BASE), .DEPTH(1024)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef DMEM_ARB_STAT_EN
        ,
        .p0_grant_cnt(p0_grant_cnt),
        .p1_grant_cnt(p1_grant_cnt),
        .err_cnt(err_cnt)
`endif
    );

    // Memory model: combinational formatted reads, writes on the clock edge
    logic [7:0]  mem [0:1023];
    logic [31:0] rd_off, wr_off;
    logic [9:0]  ri, wi;
    logic [7:0]  b0, b1, b2, b3;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] <= 8'(i);
    end

    always_comb begin
        rd_off = bus.mem_raddr - BASE;
        ri = rd_off[9:0];
        b0 = mem[ri];
        b1 = mem[ri + 10'd1];
        b2 = mem[ri + 10'd2];
        b3 = mem[ri + 10'd3];
        case (bus.mem_choose)
            3'd0:    bus.mem_rdata = {{24{b0[7]}}, b0};
            3'd1:    bus.mem_rdata = {24'h0, b0};
            3'd2:    bus.mem_rdata = {{16{b0[7]}}, b0, b1};
            3'd3:    bus.mem_rdata = {16'h0, b0, b1};
            3'd4:    bus.mem_rdata = {b0, b1, b2, b3};
            default: bus.mem_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (bus.mem_wena) begin
            wr_off = bus.mem_waddr - BASE;
            wi = wr_off[9:0];
            case (bus.mem_choose)
                3'd5: mem[wi] <= bus.mem_wdata[7:0];
                3'd7: begin
                    mem[wi]         <= bus.mem_wdata[15:8];
                    mem[wi + 10'd1] <= bus.mem_wdata[7:0];
                end
                3'd6: begin
                    mem[wi]         <= bus.mem_wdata[31:24];
                    mem[wi + 10'd1] <= bus.mem_wdata[23:16];
                    mem[wi + 10'd2] <= bus.mem_wdata[15:8];
                    mem[wi + 10'd3] <= bus.mem_wdata[7:0];
                end
                default: ;
            endcase
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit port, input bit req, input bit we, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_op = op; bus.p1_addr = addr; bus.p1_wdata = wdata;
        end else begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_op = op; bus.p0_addr = addr; bus.p0_wdata = wdata;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    // Single transaction on one port; reports ack latency (-1 on timeout)
    task automatic do_tx(input bit port, input bit we, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output bit err, output logic [31:0] rdata,
                         output bit wena, output bit other);
        lat = -1; err = 1'b0; rdata = 32'h0; wena = 1'b0; other = 1'b0;
        drive(port, 1'b1, we, op, addr, wdata);
        for (int k = 1; k <= 8; k++) begin
            tick;
            if (bus.mem_wena) wena = 1'b1;
            if (port ? bus.p0_ack : bus.p1_ack) other = 1'b1;
            if (port ? bus.p1_ack : bus.p0_ack) begin
                lat = k;
                err = port ? bus.p1_err : bus.p0_err;
                rdata = port ? bus.p1_rdata : bus.p0_rdata;
                break;
            end
        end
        drive(port, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        tick;
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vt [16];
    int          lat, acks_seen;
    bit          err, wena, other;
    logic [31:0] rdata;
    int          exp_t [4];
    bit          exp_p [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{1'b0, 1'b1, 3'd6, BASE,             32'hAABBCCDD, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 1'b0, 3'd4, BASE,             32'h0,        1'b0, 32'hAABBCCDD};
        vt[2]  = '{1'b0, 1'b0, 3'd0, BASE + 32'd1,     32'h0,        1'b0, 32'hFFFFFFBB};
        vt[3]  = '{1'b0, 1'b0, 3'd1, BASE + 32'd1,     32'h0,        1'b0, 32'h000000BB};
        vt[4]  = '{1'b1, 1'b1, 3'd6, BASE + 32'd2,     32'h11223344, 1'b1, 32'h0};
        vt[5]  = '{1'b1, 1'b0, 3'd4, BASE,             32'h0,        1'b0, 32'hAABBCCDD};
        vt[6]  = '{1'b0, 1'b0, 3'd4, BASE + 32'h3FE,   32'h0,        1'b1, 32'h0};
        vt[7]  = '{1'b0, 1'b0, 3'd4, 32'h1000_FFFC,    32'h0,        1'b1, 32'h0};
        vt[8]  = '{1'b0, 1'b0, 3'd2, BASE + 32'd1,     32'h0,        1'b1, 32'h0};
        vt[9]  = '{1'b0, 1'b0, 3'd5, BASE,             32'h0,        1'b1, 32'h0};
        vt[10] = '{1'b1, 1'b1, 3'd4, BASE,             32'hDEADBEEF, 1'b1, 32'h0};
        vt[11] = '{1'b1, 1'b0, 3'd0, BASE + 32'h3FF,   32'h0,        1'b0, 32'hFFFFFFFF};
        vt[12] = '{1'b1, 1'b0, 3'd3, BASE + 32'h3FE,   32'h0,        1'b0, 32'h0000FEFF};
        vt[13] = '{1'b0, 1'b1, 3'd7, BASE + 32'd8,     32'hFFFF8001, 1'b0, 32'h0};
        vt[14] = '{1'b0, 1'b0, 3'd2, BASE + 32'd8,     32'h0,        1'b0, 32'hFFFF8001};
        vt[15] = '{1'b1, 1'b0, 3'd4, BASE + 32'h3FC,   32'h0,        1'b0, 32'hFCFDFEFF};

        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);

        // Reset state
        rst = 1'b1;
        tick;
        tick;
        check("rst_p0_ack",   32'(bus.p0_ack), 32'h0);
        check("rst_p1_ack",   32'(bus.p1_ack), 32'h0);
        check("rst_p0_err",   32'(bus.p0_err), 32'h0);
        check("rst_p1_err",   32'(bus.p1_err), 32'h0);
        check("rst_p0_rdata", bus.p0_rdata, 32'h0);
        check("rst_p1_rdata", bus.p1_rdata, 32'h0);
        check("rst_wena",     32'(bus.mem_wena), 32'h0);
        check("rst_raddr",    bus.mem_raddr, 32'h0);
        check("rst_choose",   32'(bus.mem_choose), 32'h0);
        rst = 1'b0;

        // Both ports hold LW requests: port 0 first, then strict alternation every 3 cycles
        exp_t = '{2, 5, 8, 11};
        exp_p = '{1'b0, 1'b1, 1'b0, 1'b1};
        acks_seen = 0;
        drive(1'b0, 1'b1, 1'b0, 3'd4, BASE,          32'h0);
        drive(1'b1, 1'b1, 1'b0, 3'd4, BASE + 32'd4,  32'h0);
        for (int k = 1; k <= 20 && acks_seen < 4; k++) begin
            tick;
            if (bus.p0_ack || bus.p1_ack) begin
                check("tie_excl",  32'(bus.p0_ack & bus.p1_ack), 32'h0);
                check("tie_port",  32'(bus.p1_ack), 32'(exp_p[acks_seen]));
                check("tie_cycle", 32'(k), 32'(exp_t[acks_seen]));
                check("tie_rdata", exp_p[acks_seen] ? bus.p1_rdata : bus.p0_rdata,
                      exp_p[acks_seen] ? 32'h04050607 : 32'h00010203);
                acks_seen++;
            end
        end
        check("tie_count", 32'(acks_seen), 32'd4);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        tick;

        // Table of single-port transactions
        for (int i = 0; i < 16; i++) begin
            do_tx(vt[i].port, vt[i].we, vt[i].op, vt[i].addr, vt[i].wdata, lat, err, rdata, wena, other);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            check($sformatf("vec%0d_err", i),     32'(err), 32'(vt[i].exp_err));
            check($sformatf("vec%0d_rdata", i),   rdata, vt[i].exp_rdata);
            check($sformatf("vec%0d_wena", i),    32'(wena), 32'(vt[i].we & ~vt[i].exp_err));
            check($sformatf("vec%0d_other", i),   32'(other), 32'h0);
        end

        // Reset during ACCESS of an SH: no store, no ack
        drive(1'b0, 1'b1, 1'b1, 3'd7, BASE + 32'd4, 32'h00001234);
        tick;
        check("rstacc_wena_before", 32'(bus.mem_wena), 32'h1);
        rst = 1'b1;
        #1;
        check("rstacc_wena_forced", 32'(bus.mem_wena), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        tick;
        rst = 1'b0;
        check("rstacc_ack0", 32'(bus.p0_ack), 32'h0);
        tick;
        check("rstacc_ack1", 32'(bus.p0_ack), 32'h0);
        check("rstacc_mem",  32'({mem[4], mem[5]}), 32'h0405);
        do_tx(1'b0, 1'b0, 3'd3, BASE + 32'd4, 32'h0, lat, err, rdata, wena, other);
        check("rstacc_lhu_lat",   32'(lat), 32'd2);
        check("rstacc_lhu_rdata", rdata, 32'h00000405);

`ifdef DMEM_ARB_STAT_EN
        do_reset;
        check("stat_rst_p0",  32'(p0_grant_cnt), 32'h0);
        check("stat_rst_p1",  32'(p1_grant_cnt), 32'h0);
        check("stat_rst_err", 32'(err_cnt),      32'h0);
        for (int i = 0; i < 3; i++)
            do_tx(1'b0, 1'b0, 3'd4, BASE, 32'h0, lat, err, rdata, wena, other);
        do_tx(1'b0, 1'b0, 3'd4, BASE + 32'd2, 32'h0, lat, err, rdata, wena, other);
        for (int i = 0; i < 2; i++)
            do_tx(1'b1, 1'b0, 3'd4, BASE, 32'h0, lat, err, rdata, wena, other);
        check("stat_p0",  32'(p0_grant_cnt), 32'd4);
        check("stat_p1",  32'(p1_grant_cnt), 32'd2);
        check("stat_err", 32'(err_cnt),      32'd1);
        force dut.err_cnt = 16'hFFFE;
        #1;
        release dut.err_cnt;
        do_tx(1'b1, 1'b1, 3'd4, BASE, 32'h0, lat, err, rdata, wena, other);
        check("stat_err_max", 32'(err_cnt), 32'hFFFF);
        do_tx(1'b1, 1'b1, 3'd4, BASE, 32'h0, lat, err, rdata, wena, other);
        check("stat_err_sat", 32'(err_cnt), 32'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single byte-addressed, big-endian data memory between two requesters: port 0 (CPU load/store unit) and port 1 (loader/debug DMA).
- Sequences each access as a fixed three-state transaction.
- Checks address range, alignment and opcode/direction before any access reaches memory.
- Returns registered read data with a one-cycle ack pulse.

Parameters:
- BASE_ADDR, 32'h1001_0000, byte address of memory location 0.
- DEPTH, 1024, memory size in bytes; valid range is BASE_ADDR .. BASE_ADDR+DEPTH-1.
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- p0_req, p1_req  in  1 each  request; held high with payload stable until that port's ack.
- p0_we, p1_we  in  1 each  1 = store, 0 = load.
- p0_addr, p1_addr  in  32 each  byte address.
- p0_wdata, p1_wdata  in  32 each  store data (SB uses [7:0], SH uses [15:0]).
- p0_op, p1_op  in  3 each  access code: LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SW=6, SH=7.
- p0_ack, p1_ack  out  1 each  one-cycle completion pulse.
- p0_err, p1_err  out  1 each  valid with ack; 1 = rejected, no memory effect.
- p0_rdata, p1_rdata  out  32 each  load result, valid with ack.
- mem_wena  out  1  to memory write enable.
- mem_raddr, mem_waddr  out  32 each  to memory; both driven with the granted address.
- mem_wdata  out  32  to memory.
- mem_choose  out  3  to memory access code.
- mem_rdata  in  32  from memory; combinational read data.

Behaviour:
- Reset: state=IDLE, rr_last=1 (port 0 wins first tie), all acks/errs 0, rdata 0, mem_* registers 0, mem_wena 0.
- IDLE:
  - If any req is high, select a winner: a single requester wins outright; on a tie, the port != rr_last wins.
  - Latch the winner's we/addr/wdata/op into the mem_* registers, compute err, set rr_last=winner, go to ACCESS.
- ACCESS (1 cycle):
  - mem_wena = we & ~err & ~rst; the store commits at the end of this cycle.
  - For loads, mem_rdata is sampled into the winner's rdata register at the end of this cycle.
  - Go to RESP.
- RESP (1 cycle):
  - Winner's ack=1; err as computed.
  - rdata is held from ACCESS for a valid load, and is 0 for stores and errors.
  - Go to IDLE; the requester drops or re-issues req in the following cycle.
- Latency: req seen in cycle N -> ack in cycle N+2.
  - Back-to-back transactions: one every 3 cycles.
  - With both ports requesting continuously, grants alternate 0,1,0,1.
- err is set when any of the following holds:
  - (addr - BASE_ADDR) >= DEPTH (unsigned; addresses below base wrap and fail);
  - the last byte touched (addr + size - 1) is outside the range;
  - the access is misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0;
  - the op mismatches the direction: we=1 with op<5, or we=0 with op>=5.
- On err: mem_wena stays 0, rdata=0, ack still pulses.
- The loser's req is ignored until the next IDLE; it is never dropped.
- Payload changes while req is high and before ack are undefined (the requester's violation); the latched copy is used.
- req deasserted mid-transaction: the transaction completes and the ack is still issued.
- rst during ACCESS: mem_wena is forced 0 that same cycle (no partial store), no ack, state goes to IDLE.
- mem_choose holds its last value in IDLE; mem_wena is 0 outside ACCESS.

Optional Feature:
- DMEM_ARB_STAT_EN defined: adds outputs p0_grant_cnt, p1_grant_cnt and err_cnt, each CNT_W bits.
  - These increment in RESP for the winner, and for err respectively.
  - They saturate at all-ones and clear on rst.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- p0 SW addr 0x10010000 wdata 0xAABBCCDD, then p0 LW same addr:
  - ack at N+2 each, err=0, rdata=0xAABBCCDD.
  - p0 LB 0x10010001 -> rdata=0xFFFFFFBB.
  - p0 LBU 0x10010001 -> rdata=0x000000BB.
- p0 and p1 both assert req with LW from reset:
  - p0 acks first, p1 acks 3 cycles later.
  - Repeated simultaneous requests alternate 1,0,1.
- p1 SW at 0x10010002 (misaligned):
  - ack with err=1, mem_wena never high, the word at 0x10010000 is unchanged.
- p0 LW at 0x100103FE (runs past DEPTH) and p0 LW at 0x1000FFFC (below base):
  - both ack with err=1, rdata=0.
- p0 SH 0x10010004 wdata 0x00001234 with rst pulsed during ACCESS:
  - no ack, memory at 0x10010004 is unchanged.
  - The next LHU there returns its old value.
- With DMEM_ARB_STAT_EN, run 3 p0, 2 p1 and 1 erroring transaction:
  - counts are 4/2/1 (p0 includes the erroring one).
  - A forced near-max preload saturates the counter at all-ones.
